// File: rtl/int_controller_pkg.sv
// rtl/int_controller_pkg.sv - shared types and constants for the interrupt controller
package int_controller_pkg;

  localparam int ID_W = 5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQUEST = 2'd1,
    SERVICE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    TRIG_LVL_HI = 2'b00,
    TRIG_LVL_LO = 2'b01,
    TRIG_RISE   = 2'b10,
    TRIG_FALL   = 2'b11
  } trig_t;

endpackage

// File: rtl/int_controller_if.sv
// rtl/int_controller_if.sv - req/ack/ret handshake between interrupt controller and control unit
interface int_controller_if;
  import int_controller_pkg::*;

  logic            int_req;
  logic [7:0]      int_vector;
  logic [ID_W-1:0] int_id;
  logic            int_busy;
  logic            int_ack;
  logic            int_ret;

  modport master (
    output int_req, int_vector, int_id, int_busy,
    input  int_ack, int_ret
  );

  modport slave (
    input  int_req, int_vector, int_id, int_busy,
    output int_ack, int_ret
  );

endinterface

// File: rtl/int_controller_src_cond.sv
// rtl/int_controller_src_cond.sv - per-source synchroniser, edge detect and pending flop
module int_controller_src_cond
  import int_controller_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic  clock,
  input  logic  nreset,
  input  logic  src,
  input  trig_t mode,
  input  logic  ack_clr,
  output logic  pending
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   s;
  logic                   pending_d;

  assign s = sync_q[SYNC_STAGES-1];

  // Edge modes hold until acknowledged; a new edge in the ack cycle wins over the clear.
  always_comb begin
    pending_d = pending;
    case (mode)
      TRIG_LVL_HI: pending_d = s;
      TRIG_LVL_LO: pending_d = ~s;
      TRIG_RISE: begin
        if (s && !prev_q)  pending_d = 1'b1;
        else if (ack_clr)  pending_d = 1'b0;
      end
      TRIG_FALL: begin
        if (!s && prev_q)  pending_d = 1'b1;
        else if (ack_clr)  pending_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      sync_q  <= '0;
      prev_q  <= 1'b0;
      pending <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], src};
      prev_q  <= s;
      pending <= pending_d;
    end
  end

endmodule

// File: rtl/int_controller.sv
// rtl/int_controller.sv - prioritising interrupt controller with req/ack/ret handshake
module int_controller
  import int_controller_pkg::*;
#(
  parameter int N_SRC       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int VEC_SHIFT   = 2
) (
  input  logic               clock,
  input  logic               nreset,
  input  logic [N_SRC-1:0]   int_src,
  input  logic               int_en,
  input  logic [N_SRC-1:0]   int_mask,
  input  logic [2*N_SRC-1:0] int_trig,
  input  logic [7:0]         vector_base,
  output logic [N_SRC-1:0]   int_pending,
  int_controller_if.master   cu
);

  state_t          state_q, state_d;
  logic            req_q, req_d;
  logic            busy_q, busy_d;
  logic [ID_W-1:0] id_q, id_d;
  logic [7:0]      vec_q, vec_d;
  logic [N_SRC-1:0] ack_clr;
  logic [N_SRC-1:0] eligible;
  logic [ID_W-1:0] sel;
  logic [7:0]      sel_off;

  function automatic logic [ID_W-1:0] lowest_set(input logic [N_SRC-1:0] v);
    lowest_set = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (v[i]) lowest_set = ID_W'(i);
    end
  endfunction

  for (genvar i = 0; i < N_SRC; i++) begin : g_src
    int_controller_src_cond #(.SYNC_STAGES(SYNC_STAGES)) u_cond (
      .clock   (clock),
      .nreset  (nreset),
      .src     (int_src[i]),
      .mode    (trig_t'(int_trig[2*i+1 -: 2])),
      .ack_clr (ack_clr[i]),
      .pending (int_pending[i])
    );
  end

  assign eligible = int_pending & int_mask;
  assign sel      = lowest_set(eligible);
  assign sel_off  = {{(8-ID_W){1'b0}}, sel} << VEC_SHIFT;

  // Id and vector are frozen once REQUEST is entered, so a later higher-priority source waits.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    busy_d  = busy_q;
    id_d    = id_q;
    vec_d   = vec_q;
    ack_clr = '0;
    case (state_q)
      IDLE: begin
        if (int_en && |eligible) begin
          state_d = REQUEST;
          req_d   = 1'b1;
          id_d    = sel;
          vec_d   = vector_base + sel_off;
        end
      end
      REQUEST: begin
        if (cu.int_ack) begin
          ack_clr[id_q] = 1'b1;
          state_d       = SERVICE;
          req_d         = 1'b0;
          busy_d        = 1'b1;
        end else if (!int_en) begin
          state_d = IDLE;
          req_d   = 1'b0;
        end
      end
      SERVICE: begin
        if (cu.int_ret) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      busy_q  <= 1'b0;
      id_q    <= '0;
      vec_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      busy_q  <= busy_d;
      id_q    <= id_d;
      vec_q   <= vec_d;
    end
  end

  assign cu.int_req    = req_q;
  assign cu.int_busy   = busy_q;
  assign cu.int_id     = id_q;
  assign cu.int_vector = vec_q;

endmodule

// File: tb/tb_int_controller.sv
// tb/tb_int_controller.sv - directed self-checking bench for int_controller
module tb_int_controller;

  logic        clock;
  logic        nreset;
  logic [31:0] int_src;
  logic        int_en;
  logic [31:0] int_mask;
  logic [63:0] int_trig;
  logic [7:0]  vector_base;
  logic [31:0] int_pending;

  int checks;
  int errors;

  int_controller_if cu_if ();

  int_controller #(.N_SRC(32), .SYNC_STAGES(2), .VEC_SHIFT(2)) dut (
    .clock       (clock),
    .nreset      (nreset),
    .int_src     (int_src),
    .int_en      (int_en),
    .int_mask    (int_mask),
    .int_trig    (int_trig),
    .vector_base (vector_base),
    .int_pending (int_pending),
    .cu          (cu_if.master)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic step(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic pulse_ack();
    cu_if.int_ack = 1'b1;
    step();
    cu_if.int_ack = 1'b0;
  endtask

  task automatic pulse_ret();
    cu_if.int_ret = 1'b1;
    step();
    cu_if.int_ret = 1'b0;
  endtask

  task automatic chk_outputs(input string tag, input logic req, input logic [7:0] vec,
                             input logic [4:0] id, input logic busy);
    chk({tag, "_req"},  32'(cu_if.int_req),    32'(req));
    chk({tag, "_vec"},  32'(cu_if.int_vector), 32'(vec));
    chk({tag, "_id"},   32'(cu_if.int_id),     32'(id));
    chk({tag, "_busy"}, 32'(cu_if.int_busy),   32'(busy));
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    nreset        = 1'b0;
    int_src       = '0;
    int_en        = 1'b0;
    int_mask      = '0;
    int_trig      = {32{2'b10}};
    vector_base   = 8'h00;
    cu_if.int_ack = 1'b0;
    cu_if.int_ret = 1'b0;

    // 1: reset state, then asynchronous reset in the middle of REQUEST
    step(2);
    chk_outputs("rst0", 1'b0, 8'h00, 5'd0, 1'b0);
    chk("rst0_pend", int_pending, 32'h0);
    nreset = 1'b1;
    int_src = 32'hFFFF_FFFF;
    int_mask = 32'hFFFF_FFFF;
    int_en = 1'b1;
    vector_base = 8'h40;
    step(4);
    chk_outputs("pre_rst", 1'b1, 8'h40, 5'd0, 1'b0);
    nreset = 1'b0;
    #1;
    chk_outputs("mid_rst", 1'b0, 8'h00, 5'd0, 1'b0);
    chk("mid_rst_pend", int_pending, 32'h0);
    int_src = '0;
    step(2);
    nreset = 1'b1;
    step(4);
    chk("post_rst_req", 32'(cu_if.int_req), 32'h0);
    chk("post_rst_pend", int_pending, 32'h0);

    // 2: rising edge on source 0, latency and handshake
    int_mask = 32'h1;
    int_src[0] = 1'b1;
    step(3);
    chk("rise_pend_k2", int_pending, 32'h1);
    chk("rise_req_k2", 32'(cu_if.int_req), 32'h0);
    step();
    chk_outputs("rise_req_k3", 1'b1, 8'h40, 5'd0, 1'b0);
    pulse_ack();
    chk("rise_ack_pend", int_pending, 32'h0);
    chk_outputs("rise_ack", 1'b0, 8'h40, 5'd0, 1'b1);
    pulse_ret();
    chk("rise_ret_busy", 32'(cu_if.int_busy), 32'h0);
    step();
    chk("rise_idle_req", 32'(cu_if.int_req), 32'h0);

    // 3: simultaneous edges on 5 and 2, lower index first
    vector_base = 8'h00;
    int_mask = 32'hFFFF_FFFF;
    int_src[2] = 1'b1;
    int_src[5] = 1'b1;
    step(3);
    chk("prio_pend", int_pending, 32'h24);
    step();
    chk_outputs("prio_first", 1'b1, 8'h08, 5'd2, 1'b0);
    pulse_ack();
    pulse_ret();
    step();
    chk_outputs("prio_second", 1'b1, 8'h14, 5'd5, 1'b0);
    pulse_ack();
    pulse_ret();
    int_src = '0;
    step(4);
    chk("prio_done_req", 32'(cu_if.int_req), 32'h0);
    chk("prio_done_pend", int_pending, 32'h0);

    // 4: level-low source 1 keeps re-requesting until driven high
    int_trig[3:2] = 2'b01;
    step();
    chk("lvl_pend", int_pending, 32'h2);
    step();
    chk_outputs("lvl_req", 1'b1, 8'h04, 5'd1, 1'b0);
    pulse_ack();
    chk("lvl_ack_pend", int_pending, 32'h2);
    chk("lvl_ack_busy", 32'(cu_if.int_busy), 32'h1);
    pulse_ret();
    chk("lvl_ret_busy", 32'(cu_if.int_busy), 32'h0);
    step();
    chk_outputs("lvl_rereq", 1'b1, 8'h04, 5'd1, 1'b0);
    int_src[1] = 1'b1;
    pulse_ack();
    step(2);
    chk("lvl_high_pend", int_pending, 32'h0);
    pulse_ret();
    step();
    chk("lvl_high_req", 32'(cu_if.int_req), 32'h0);
    int_trig[3:2] = 2'b10;

    // 5: masked edge still latches; enable drop withdraws the request
    int_mask = ~32'h8;
    int_src[3] = 1'b1;
    step(3);
    chk("mask_pend", int_pending, 32'h8);
    step();
    chk("mask_req", 32'(cu_if.int_req), 32'h0);
    int_mask = 32'hFFFF_FFFF;
    step();
    chk_outputs("unmask_req", 1'b1, 8'h0C, 5'd3, 1'b0);
    int_en = 1'b0;
    step();
    chk("en_drop_req", 32'(cu_if.int_req), 32'h0);
    chk("en_drop_pend", int_pending, 32'h8);
    int_en = 1'b1;
    step();
    chk("en_back_req", 32'(cu_if.int_req), 32'h1);
    pulse_ack();
    chk("en_ack_pend", int_pending, 32'h0);
    pulse_ret();

    // 6: vector wrap, edge during the ack cycle, ack while idle
    vector_base = 8'hF8;
    int_src[3] = 1'b0;
    step(3);
    int_src[3] = 1'b1;
    step(4);
    chk_outputs("wrap", 1'b1, 8'h04, 5'd3, 1'b0);
    int_src[3] = 1'b0;
    step(3);
    int_src[3] = 1'b1;
    step(2);
    pulse_ack();
    chk("ack_edge_pend", int_pending, 32'h8);
    chk("ack_edge_busy", 32'(cu_if.int_busy), 32'h1);
    int_en = 1'b0;
    pulse_ret();
    chk("idle_busy", 32'(cu_if.int_busy), 32'h0);
    pulse_ack();
    chk("idle_ack_pend", int_pending, 32'h8);
    chk_outputs("idle_ack", 1'b0, 8'h04, 5'd3, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
